// File: rtl/inst_queue.sv
// Instruction queue: FIFO of {pc, instr, excp} between fetch and decode, with single-cycle flush.
// Optional combinational empty-queue bypass when INST_QUEUE_BYPASS_EN is defined.
module inst_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    input  logic                     in_excp,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic                     out_excp,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = PC_W + INSTR_W + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [EntW-1:0] mem_q [DEPTH];
    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic            bypass;
    logic            push, pop, push_st, pop_st;
    logic [EntW-1:0] in_ent, sel_ent, out_ent;

    assign in_ent = {in_pc, in_instr, in_excp};

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = (count_q == '0) && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = !flush && (count_q != Full);
    assign out_valid = !flush && ((count_q != '0) || bypass);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign push_st = push && !(bypass && out_ready);
    assign pop_st  = pop && !bypass;

    assign sel_ent = bypass ? in_ent : mem_q[head_q];
    assign out_ent = out_valid ? sel_ent : '0;
    assign {out_pc, out_instr, out_excp} = out_ent;
    assign count = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_st) tail_d = tail_q + PtrW'(1);
        if (pop_st)  head_d = head_q + PtrW'(1);
        if (push_st && !pop_st) begin
            count_d = count_q + CntW'(1);
        end else if (!push_st && pop_st) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!rst && push_st) mem_q[tail_q] <= in_ent;
    end

endmodule
